// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
//
// Purpose:
//   Turns single-cycle event pulses into fixed-width high windows on out_level.
//   Each accepted event produces one HOLD_CYCLES-wide high window, followed by
//   a GAP_CYCLES low guard. Events that arrive while a window or guard is
//   running are counted in a saturating pending counter. They are then replayed
//   back-to-back, so no two events are ever merged into one window.
//
// Ports:
//   clk        in   system clock, everything on the rising edge
//   rst        in   synchronous active-high reset (highest priority)
//   in_pulse   in   event input; every high cycle is one event
//   clear      in   synchronous flush of window, queue and overflow flag
//   out_level  out  stretched level (high while in HOLD)
//   busy       out  high while a window or guard is running
//   pend_count out  queued events that have not started yet
//   overflow   out  sticky flag: an event was dropped on a full queue
// -----------------------------------------------------------------------------
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_pulse,
    input  logic              clear,
    output logic              out_level,
    output logic              busy,
    output logic [PEND_W-1:0] pend_count,
    output logic              overflow
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Counters are loaded with length-1 so that the cycle where cnt==0 is the
    // last cycle of the state.
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               overflow_q, overflow_d;
    logic               out_level_q, out_level_d;
    logic               busy_q, busy_d;

    logic               active;
    logic               last_gap;
    logic               pend_nz;
    logic               start;
    logic               inc;
    logic               dec;

    // Queue control terms derived from the current state
    always_comb begin
        active   = (state_q == ST_HOLD) || (state_q == ST_GAP);
        last_gap = (state_q == ST_GAP) && (cnt_q == CNT_ZERO);
        pend_nz  = (pend_q != PEND_ZERO);
        start    = last_gap && (pend_nz || in_pulse);
        // A pulse on the last guard cycle with an empty queue starts the next
        // window directly instead of passing through the queue.
        inc      = active && in_pulse && !(last_gap && !pend_nz);
        dec      = last_gap && pend_nz;
    end

    // Next-state, counter, queue and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        overflow_d  = overflow_q;
        out_level_d = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_pulse) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q != CNT_ZERO) begin
                    state_d = ST_GAP;
                    cnt_d   = cnt_q - CNT_ONE;
                end else if (start) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        // Saturating queue: a simultaneous inc and dec cancel out, and a full
        // queue drops the event and raises the sticky flag.
        if (inc && !dec) begin
            if (pend_q == PEND_MAX) begin
                pend_d     = pend_q;
                overflow_d = 1'b1;
            end else begin
                pend_d     = pend_q + PEND_ONE;
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - PEND_ONE;
        end else begin
            pend_d = pend_q;
        end

        // Flush overrides everything above, including a coincident pulse
        if (clear) begin
            state_d    = ST_IDLE;
            cnt_d      = CNT_ZERO;
            pend_d     = PEND_ZERO;
            overflow_d = 1'b0;
        end else begin
            state_d    = state_d;
        end

        out_level_d = (state_d == ST_HOLD);
        busy_d      = (state_d == ST_HOLD) || (state_d == ST_GAP);
    end

    // State, counter, queue and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            pend_q      <= PEND_ZERO;
            overflow_q  <= 1'b0;
            out_level_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            overflow_q  <= overflow_d;
            out_level_q <= out_level_d;
            busy_q      <= busy_d;
        end
    end

    assign out_level  = out_level_q;
    assign busy       = busy_q;
    assign pend_count = pend_q;
    assign overflow   = overflow_q;

endmodule
